// File: rtl/seq_pkg.sv
// Shared types and constants for the program-counter sequencer and its return stack.
package seq_pkg;

    typedef enum logic [2:0] {
        ACT_IRQ,
        ACT_RET,
        ACT_CALL,
        ACT_JMP,
        ACT_INC,
        ACT_HOLD
    } action_e;

    localparam logic [15:0] IRQ_VEC_DEFAULT = 16'h0004;

    // Ceiling log2; evaluated at elaboration for widths.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ret_stack.sv
// Hardware LIFO for return addresses; ignores push when full, pop when empty (reads 0).
module ret_stack
    import seq_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 8,
    localparam int AW   = clog2(DEPTH),
    localparam int DW   = AW + 1
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [DW-1:0] depth,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [DW-1:0] depth_q;
    logic [DW-1:0] depth_d;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] top_ptr;

    assign full    = (depth_q == DW'(DEPTH));
    assign empty   = (depth_q == '0);
    assign wr_ptr  = depth_q[AW-1:0];
    assign top_ptr = wr_ptr - AW'(1);
    assign depth   = depth_q;

    // Top-of-stack is read asynchronously so a pop lands in the PC on the same edge.
    assign dout = empty ? '0 : mem[top_ptr];

    always_comb begin
        depth_d = depth_q;
        if (push && !full) begin
            depth_d = depth_q + DW'(1);
        end else if (pop && !empty) begin
            depth_d = depth_q - DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with call/return stack and edge-triggered, non-nesting interrupt entry.
module pc_sequencer
    import seq_pkg::*;
#(
    parameter int              PC_W    = 16,
    parameter int              DEPTH   = 8,
    parameter logic [PC_W-1:0] IRQ_VEC = PC_W'(IRQ_VEC_DEFAULT)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   PCpp,
    input  logic                   JMP,
    input  logic                   ret,
    input  logic                   Call,
    input  logic [PC_W-1:0]        addr_in,
    input  logic                   IRQ,
    input  logic                   IE,
    output logic                   interrupt,
    output logic [PC_W-1:0]        PC,
    output logic                   in_isr,
    output logic [clog2(DEPTH):0]  stk_depth,
    output logic                   stk_err
);

    localparam int DW = clog2(DEPTH) + 1;

    logic [PC_W-1:0] pc_q, pc_d;
    logic            in_isr_q, in_isr_d;
    logic            stk_err_q, stk_err_d;
    logic            pend_q, pend_d;
    logic            irq_dly_q;
    logic [DW-1:0]   isr_mark_q, isr_mark_d;

    logic            stk_push;
    logic            stk_pop;
    logic [PC_W-1:0] stk_din;
    logic [PC_W-1:0] stk_dout;
    logic [DW-1:0]   stk_depth_w;
    logic            stk_full;
    logic            stk_empty;

    action_e         act;

    assign interrupt = pend_q & IE & ~in_isr_q;
    assign PC        = pc_q;
    assign in_isr    = in_isr_q;
    assign stk_depth = stk_depth_w;
    assign stk_err   = stk_err_q;

    // ret outranks JMP because decode drives both for a return instruction.
    always_comb begin
        if (interrupt) begin
            act = ACT_IRQ;
        end else if (ret) begin
            act = ACT_RET;
        end else if (Call) begin
            act = ACT_CALL;
        end else if (JMP) begin
            act = ACT_JMP;
        end else if (PCpp) begin
            act = ACT_INC;
        end else begin
            act = ACT_HOLD;
        end
    end

    always_comb begin
        pc_d       = pc_q;
        in_isr_d   = in_isr_q;
        stk_err_d  = stk_err_q;
        isr_mark_d = isr_mark_q;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        stk_din    = pc_q;
        // A fresh edge in the accept cycle must survive the clear.
        pend_d     = (pend_q & (act != ACT_IRQ)) | (IRQ & ~irq_dly_q);
        case (act)
            ACT_IRQ: begin
                stk_push   = 1'b1;
                stk_din    = pc_q;
                pc_d       = IRQ_VEC;
                in_isr_d   = 1'b1;
                isr_mark_d = stk_depth_w;
                if (stk_full) begin
                    stk_err_d = 1'b1;
                end
            end
            ACT_RET: begin
                stk_pop = 1'b1;
                if (stk_empty) begin
                    pc_d      = '0;
                    stk_err_d = 1'b1;
                    in_isr_d  = 1'b0;
                end else begin
                    pc_d = stk_dout;
                    if (in_isr_q && ((stk_depth_w - DW'(1)) == isr_mark_q)) begin
                        in_isr_d = 1'b0;
                    end
                end
            end
            ACT_CALL: begin
                stk_push = 1'b1;
                stk_din  = pc_q + PC_W'(1);
                pc_d     = addr_in;
                if (stk_full) begin
                    stk_err_d = 1'b1;
                end
            end
            ACT_JMP:  pc_d = addr_in;
            ACT_INC:  pc_d = pc_q + PC_W'(1);
            default:  pc_d = pc_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q       <= '0;
            in_isr_q   <= 1'b0;
            stk_err_q  <= 1'b0;
            pend_q     <= 1'b0;
            irq_dly_q  <= 1'b0;
            isr_mark_q <= '0;
        end else begin
            pc_q       <= pc_d;
            in_isr_q   <= in_isr_d;
            stk_err_q  <= stk_err_d;
            pend_q     <= pend_d;
            irq_dly_q  <= IRQ;
            isr_mark_q <= isr_mark_d;
        end
    end

    ret_stack #(
        .W     (PC_W),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk   (CLK),
        .srst  (RST),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (stk_din),
        .dout  (stk_dout),
        .depth (stk_depth_w),
        .full  (stk_full),
        .empty (stk_empty)
    );

endmodule
